// File: rtl/libv_pkg.sv
// Shared prefix-adder primitives: the propagate/generate pair and its
// associative combine operator.
package libv_pkg;

   typedef struct packed {
      logic p;
      logic g;
   } pg_t;

   // hi covers the more significant span, lo the adjacent less significant one.
   function automatic pg_t pg_combine(pg_t hi, pg_t lo);
      pg_t r;
      r.p = hi.p & lo.p;
      r.g = hi.g | (hi.p & lo.g);
      return r;
   endfunction

endpackage

// File: rtl/adder_pipelined_if.sv
// Request/result bundle for adder_pipelined: operand beat in, sum beat out,
// each with its own valid/ready pair.
interface adder_pipelined_if #(
   parameter int W = 32
);
   logic         in_vld;
   logic [W-1:0] in_a;
   logic [W-1:0] in_b;
   logic         in_cin;
   logic         in_rdy;
   logic         out_vld;
   logic [W-1:0] out_sum;
   logic         out_cout;
   logic         out_ovf;
   logic         out_rdy;

   modport master (
      output in_vld, in_a, in_b, in_cin, out_rdy,
      input  in_rdy, out_vld, out_sum, out_cout, out_ovf
   );

   modport slave (
      input  in_vld, in_a, in_b, in_cin, out_rdy,
      output in_rdy, out_vld, out_sum, out_cout, out_ovf
   );
endinterface

// File: rtl/carry_chain_hybrid.sv
// Parallel-prefix carry network: log2(W) levels of pg_combine, each level
// doubling the span, so c[i] is the group generate of bits i-1..0.
module carry_chain_hybrid
   import libv_pkg::*;
#(
   parameter int W = 32
) (
   input  logic [W-1:0] i_p,
   input  logic [W-1:0] i_g,
   input  logic         i_cin,
   output logic [W:0]   o_c
);

   localparam int L = $clog2(W);

   for (genvar k = 0; k <= L; k++) begin : g_lvl
      pg_t w_pg [W];
      for (genvar i = 0; i < W; i++) begin : g_bit
         if (k == 0) begin : g_leaf
            assign w_pg[i] = '{p: i_p[i], g: i_g[i]};
         end else if (i >= (1 << (k - 1))) begin : g_comb
            assign w_pg[i] = pg_combine(g_lvl[k-1].w_pg[i],
                                        g_lvl[k-1].w_pg[i - (1 << (k - 1))]);
         end else begin : g_pass
            assign w_pg[i] = g_lvl[k-1].w_pg[i];
         end
      end
   end

   // Carry-in is already folded into bit 0's generate, so the final
   // generates are the carries directly.
   assign o_c[0] = i_cin;
   for (genvar i = 0; i < W; i++) begin : g_out
      assign o_c[i+1] = g_lvl[L].w_pg[i].g;
   end

endmodule

// File: rtl/adder_pipelined.sv
// Two-stage valid/ready adder: S1 registers propagate/generate/cin, S2
// registers the prefix-network result (sum, unsigned carry, signed overflow).
module adder_pipelined
   import libv_pkg::*;
#(
   parameter int W = 32
) (
   input  logic             clk,
   input  logic             rst,
   adder_pipelined_if.slave bus
);

   logic         r_s1_vld;
   logic [W-1:0] r_s1_p;
   logic [W-1:0] r_s1_g;
   logic         r_s1_cin;

   logic         r_s2_vld;
   logic [W-1:0] r_s2_sum;
   logic         r_s2_cout;
   logic         r_s2_ovf;

   logic         w_s2_free;
   logic         w_s1_adv;
   logic         w_in_rdy;
   logic         w_s1_acc;
   logic [W-1:0] w_g_fold;
   logic [W:0]   w_c;

   // S2 can take a beat if it is empty or its current beat leaves this cycle.
   assign w_s2_free = !r_s2_vld || bus.out_rdy;
   assign w_s1_adv  = r_s1_vld && w_s2_free;
   assign w_in_rdy  = !r_s1_vld || w_s1_adv;
   assign w_s1_acc  = bus.in_vld && w_in_rdy;

   assign w_g_fold  = {r_s1_g[W-1:1], r_s1_g[0] | (r_s1_p[0] & r_s1_cin)};

   carry_chain_hybrid #(
      .W (W)
   ) u_carry (
      .i_p   (r_s1_p),
      .i_g   (w_g_fold),
      .i_cin (r_s1_cin),
      .o_c   (w_c)
   );

   // NOTE: state is assigned with <= so every flop samples pre-edge values
   // and the same-cycle S2 drain / S1 advance / S1 accept compose correctly.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_s1_vld <= 1'b0;
         // NOTE: data is cleared along with the valid bit so the outputs read
         // as zero after reset rather than whatever was last captured.
         r_s1_p   <= '0;
         r_s1_g   <= '0;
         r_s1_cin <= 1'b0;
      end else begin
         if (w_s1_acc) begin
            r_s1_vld <= 1'b1;
            r_s1_p   <= bus.in_a ^ bus.in_b;
            r_s1_g   <= bus.in_a & bus.in_b;
            r_s1_cin <= bus.in_cin;
         end else if (w_s1_adv) begin
            r_s1_vld <= 1'b0;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_s2_vld  <= 1'b0;
         r_s2_sum  <= '0;
         r_s2_cout <= 1'b0;
         r_s2_ovf  <= 1'b0;
      end else begin
         if (w_s1_adv) begin
            r_s2_vld  <= 1'b1;
            r_s2_sum  <= r_s1_p ^ w_c[W-1:0];
            r_s2_cout <= w_c[W];
            r_s2_ovf  <= w_c[W] ^ w_c[W-1];
         end else if (bus.out_rdy) begin
            r_s2_vld  <= 1'b0;
         end
      end
   end

   assign bus.in_rdy   = w_in_rdy;
   assign bus.out_vld  = r_s2_vld;
   assign bus.out_sum  = r_s2_sum;
   assign bus.out_cout = r_s2_cout;
   assign bus.out_ovf  = r_s2_ovf;

endmodule

// File: tb/tb_adder_pipelined.sv
// Self-checking bench: 8-bit directed vectors and stall/reset sequences, plus
// a 32-bit random stream against a scoreboard of {ovf, cout, sum} records.
module tb_adder_pipelined;

   localparam int W8     = 8;
   localparam int W32    = 32;
   localparam int N_RAND = 10000;
   localparam int N_VEC  = 9;

   typedef struct {
      logic [7:0] a;
      logic [7:0] b;
      logic       cin;
      logic [7:0] sum;
      logic       cout;
      logic       ovf;
   } vec_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   pass_cnt  = 0;
   int   total_cnt = 0;

   logic [9:0]  sb8  [$];
   logic [33:0] sb32 [$];

   always #5 clk = ~clk;

   adder_pipelined_if #(.W(W8))  bus8 ();
   adder_pipelined_if #(.W(W32)) bus32 ();

   adder_pipelined #(.W(W8)) dut8 (
      .clk (clk),
      .rst (rst),
      .bus (bus8.slave)
   );

   adder_pipelined #(.W(W32)) dut32 (
      .clk (clk),
      .rst (rst),
      .bus (bus32.slave)
   );

   // Reference: plain wide addition; overflow from the operand/result sign rule.
   function automatic logic [9:0] model8(logic [7:0] a, logic [7:0] b, logic cin);
      logic [8:0] full;
      logic       ovf;
      full = {1'b0, a} + {1'b0, b} + {8'd0, cin};
      ovf  = (a[7] == b[7]) && (full[7] != a[7]);
      return {ovf, full};
   endfunction

   function automatic logic [33:0] model32(logic [31:0] a, logic [31:0] b, logic cin);
      logic [32:0] full;
      logic        ovf;
      full = {1'b0, a} + {1'b0, b} + {32'd0, cin};
      ovf  = (a[31] == b[31]) && (full[31] != a[31]);
      return {ovf, full};
   endfunction

   function automatic logic [31:0] pick32();
      case ($urandom_range(7))
         0:       return 32'h0000_0000;
         1:       return 32'hFFFF_FFFF;
         2:       return 32'h8000_0000;
         3:       return 32'h7FFF_FFFF;
         default: return $urandom();
      endcase
   endfunction

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      total_cnt++;
      if (act === exp) pass_cnt++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
   endtask

   task automatic pop8(input string name);
      logic [9:0] exp;
      check({name, "_avail"}, 64'(sb8.size() != 0), 64'd1);
      if (sb8.size() != 0) begin
         exp = sb8.pop_front();
         check(name, 64'({bus8.out_ovf, bus8.out_cout, bus8.out_sum}), 64'(exp));
      end
   endtask

   task automatic pop32(input string name);
      logic [33:0] exp;
      check({name, "_avail"}, 64'(sb32.size() != 0), 64'd1);
      if (sb32.size() != 0) begin
         exp = sb32.pop_front();
         check(name, 64'({bus32.out_ovf, bus32.out_cout, bus32.out_sum}), 64'(exp));
      end
   endtask

   task automatic drive8(input logic vld, input logic [7:0] a, input logic [7:0] b,
                         input logic cin);
      bus8.in_vld = vld;
      bus8.in_a   = a;
      bus8.in_b   = b;
      bus8.in_cin = cin;
   endtask

   initial begin
      vec_t vecs [N_VEC];
      int   n_acc;
      int   sent;
      int   got;
      logic acc32;

      vecs[0] = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0};
      vecs[1] = '{8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1};
      vecs[2] = '{8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b1};
      vecs[3] = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 1'b0};
      vecs[4] = '{8'h00, 8'h00, 1'b1, 8'h01, 1'b0, 1'b0};
      vecs[5] = '{8'h55, 8'hAA, 1'b0, 8'hFF, 1'b0, 1'b0};
      vecs[6] = '{8'h40, 8'h40, 1'b0, 8'h80, 1'b0, 1'b1};
      vecs[7] = '{8'hC0, 8'hC0, 1'b0, 8'h80, 1'b1, 1'b0};
      vecs[8] = '{8'h7F, 8'h80, 1'b1, 8'h00, 1'b1, 1'b0};

      drive8(1'b0, 8'h00, 8'h00, 1'b0);
      bus8.out_rdy  = 1'b0;
      bus32.in_vld  = 1'b0;
      bus32.in_a    = '0;
      bus32.in_b    = '0;
      bus32.in_cin  = 1'b0;
      bus32.out_rdy = 1'b0;

      // Reset state
      @(negedge clk);
      #1;
      check("rst_out_vld",  64'(bus8.out_vld),  64'd0);
      check("rst_in_rdy",   64'(bus8.in_rdy),   64'd1);
      check("rst_out_sum",  64'(bus8.out_sum),  64'd0);
      check("rst_out_cout", 64'(bus8.out_cout), 64'd0);
      check("rst_out_ovf",  64'(bus8.out_ovf),  64'd0);
      check("rst_out_vld32", 64'(bus32.out_vld), 64'd0);
      rst = 1'b0;

      // Directed vectors, one at a time, checking the 2-cycle latency
      bus8.out_rdy = 1'b1;
      for (int i = 0; i < N_VEC; i++) begin
         @(negedge clk);
         drive8(1'b1, vecs[i].a, vecs[i].b, vecs[i].cin);
         #1;
         check($sformatf("vec%0d_in_rdy", i), 64'(bus8.in_rdy), 64'd1);
         @(negedge clk);
         drive8(1'b0, 8'h00, 8'h00, 1'b0);
         #1;
         check($sformatf("vec%0d_lat1_vld", i), 64'(bus8.out_vld), 64'd0);
         @(negedge clk);
         #1;
         check($sformatf("vec%0d_lat2_vld", i), 64'(bus8.out_vld),  64'd1);
         check($sformatf("vec%0d_sum", i),      64'(bus8.out_sum),  64'(vecs[i].sum));
         check($sformatf("vec%0d_cout", i),     64'(bus8.out_cout), 64'(vecs[i].cout));
         check($sformatf("vec%0d_ovf", i),      64'(bus8.out_ovf),  64'(vecs[i].ovf));
      end

      // Backpressure: 4 cycles of in_vld with out_rdy low -> two beats held
      @(negedge clk);
      bus8.out_rdy = 1'b0;
      n_acc = 0;
      for (int c = 0; c < 4; c++) begin
         if (c > 0) @(negedge clk);
         drive8(1'b1, 8'(8'h30 + 16 * n_acc), 8'(8'hE0 - n_acc), 1'(n_acc));
         #1;
         check($sformatf("bp%0d_in_rdy", c), 64'(bus8.in_rdy), 64'(c < 2));
         if (c >= 2) begin
            check($sformatf("bp%0d_out_vld", c), 64'(bus8.out_vld), 64'd1);
            check($sformatf("bp%0d_hold", c),
                  64'({bus8.out_ovf, bus8.out_cout, bus8.out_sum}), 64'(sb8[0]));
         end
         if (bus8.in_vld && bus8.in_rdy) begin
            sb8.push_back(model8(bus8.in_a, bus8.in_b, bus8.in_cin));
            n_acc++;
         end
      end
      check("bp_accepted", 64'(n_acc), 64'd2);
      @(negedge clk);
      drive8(1'b0, 8'h00, 8'h00, 1'b0);
      bus8.out_rdy = 1'b1;
      #1;
      check("drain0_vld", 64'(bus8.out_vld), 64'd1);
      pop8("drain0");
      @(negedge clk);
      #1;
      check("drain1_vld", 64'(bus8.out_vld), 64'd1);
      pop8("drain1");
      @(negedge clk);
      #1;
      check("drain_done_vld", 64'(bus8.out_vld), 64'd0);
      check("drain_sb_empty", 64'(sb8.size()), 64'd0);

      // Back-to-back stream: full rate with simultaneous drain/advance/accept
      for (int k = 0; k < 6; k++) begin
         @(negedge clk);
         drive8(1'b1, 8'($urandom()), 8'($urandom()), 1'($urandom_range(1)));
         #1;
         check($sformatf("stream%0d_in_rdy", k), 64'(bus8.in_rdy), 64'd1);
         if (k >= 2) check($sformatf("stream%0d_out_vld", k), 64'(bus8.out_vld), 64'd1);
         if (bus8.out_vld) pop8($sformatf("stream%0d", k));
         if (bus8.in_vld && bus8.in_rdy) sb8.push_back(model8(bus8.in_a, bus8.in_b, bus8.in_cin));
      end
      for (int k = 0; k < 2; k++) begin
         @(negedge clk);
         drive8(1'b0, 8'h00, 8'h00, 1'b0);
         #1;
         check($sformatf("stream_tail%0d_vld", k), 64'(bus8.out_vld), 64'd1);
         pop8($sformatf("stream_tail%0d", k));
      end
      check("stream_sb_empty", 64'(sb8.size()), 64'd0);

      // Reset with two beats in flight
      @(negedge clk);
      bus8.out_rdy = 1'b0;
      drive8(1'b1, 8'hA5, 8'h5A, 1'b1);
      @(negedge clk);
      drive8(1'b1, 8'h12, 8'h34, 1'b0);
      @(negedge clk);
      drive8(1'b0, 8'h00, 8'h00, 1'b0);
      #1;
      check("mid_full_vld", 64'(bus8.out_vld), 64'd1);
      check("mid_full_rdy", 64'(bus8.in_rdy),  64'd0);
      #2;
      rst = 1'b1;
      #1;
      check("mid_rst_vld", 64'(bus8.out_vld), 64'd0);
      check("mid_rst_rdy", 64'(bus8.in_rdy),  64'd1);
      check("mid_rst_sum", 64'(bus8.out_sum), 64'd0);
      sb8.delete();
      @(negedge clk);
      rst = 1'b0;
      bus8.out_rdy = 1'b1;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         #1;
         check($sformatf("post_rst_idle%0d", k), 64'(bus8.out_vld), 64'd0);
      end
      @(negedge clk);
      drive8(1'b1, 8'h3C, 8'h5A, 1'b1);
      #1;
      sb8.push_back(model8(bus8.in_a, bus8.in_b, bus8.in_cin));
      @(negedge clk);
      drive8(1'b0, 8'h00, 8'h00, 1'b0);
      #1;
      check("post_rst_lat1", 64'(bus8.out_vld), 64'd0);
      @(negedge clk);
      #1;
      check("post_rst_lat2", 64'(bus8.out_vld), 64'd1);
      pop8("post_rst_beat");

      // Random 32-bit traffic with random backpressure
      acc32 = 1'b0;
      sent  = 0;
      got   = 0;
      for (int cyc = 0; cyc < 60000 && got < N_RAND; cyc++) begin
         @(negedge clk);
         if (acc32 || !bus32.in_vld) begin
            bus32.in_vld = (sent < N_RAND) && ($urandom_range(3) != 0);
            bus32.in_a   = pick32();
            bus32.in_b   = pick32();
            bus32.in_cin = 1'($urandom_range(1));
         end
         bus32.out_rdy = ($urandom_range(2) != 0);
         #1;
         if (bus32.out_vld && bus32.out_rdy) begin
            pop32("rand");
            got++;
         end
         acc32 = bus32.in_vld && bus32.in_rdy;
         if (acc32) begin
            sb32.push_back(model32(bus32.in_a, bus32.in_b, bus32.in_cin));
            sent++;
         end
      end
      bus32.in_vld = 1'b0;
      check("rand_beats", 64'(got), 64'(N_RAND));
      check("rand_sb_empty", 64'(sb32.size()), 64'd0);

      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
